// File: rtl/sap_mem_ctrl.sv
// sap_mem_ctrl: clocked program/data memory controller for the SAP-II datapath.
// Replaces the combinational memory with a start/done handshake and
// multi-cycle indirect operations (LDI, STA).
// Optional feature macro: SAP_MEM_STACK_EN
//   defined   -> CALL/RET use an SDEPTH-deep hardware return-address stack
//   undefined -> legacy single-level return address kept in mem[2^AW-1]
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// ACC1  | first memory access (data op, or pointer fetch for LDI/STA)
// ACC2  | second access of LDI/STA through the fetched pointer
// DONE  | result valid, done=1; start here chains the next op directly
module sap_mem_ctrl #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int SDEPTH = 4
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          lf,
    output logic [DW-1:0] dout,
    output logic [DW-1:0] dout_bus,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_LDI   = 3'b001;
    localparam logic [2:0] OP_CALL  = 3'b010;
    localparam logic [2:0] OP_STD   = 3'b011;
    localparam logic [2:0] OP_RET   = 3'b100;
    localparam logic [2:0] OP_STA   = 3'b101;
    localparam logic [2:0] OP_WRITE = 3'b110;

    state_t        state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] dout_q;
    logic [AW-1:0] ptr_q;

    logic [DW-1:0] mem [2**AW];

    logic          accept;
    logic          two_acc;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_p;
    logic [AW-1:0] ret_addr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign two_acc  = (op_q == OP_LDI) || (op_q == OP_STA);
    assign rdata_a  = mem[addr_q];
    assign rdata_p  = mem[ptr_q];
    assign ret_addr = addr_q + AW'(1);

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_ACC1;
            S_ACC1: state_d = two_acc ? S_ACC2 : S_DONE;
            S_ACC2: state_d = S_DONE;
            S_DONE: state_d = start ? S_ACC1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture; the operands stay stable for the whole operation
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_q   <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (accept) begin
            op_q   <= op;
            addr_q <= addr;
            din_q  <= din;
        end
    end

`ifdef SAP_MEM_STACK_EN
    localparam int SPW = $clog2(SDEPTH + 1);

    logic [SPW-1:0] sp_q;
    logic [AW-1:0]  stack_q [SDEPTH];
    logic           stk_full;
    logic           stk_empty;
    logic [SPW-1:0] stk_top;
    logic           push;
    logic           pop;

    assign stk_full  = (sp_q == SPW'(SDEPTH));
    assign stk_empty = (sp_q == '0);
    assign stk_top   = sp_q - SPW'(1);
    assign push      = (state_q == S_ACC1) && (op_q == OP_CALL) && !stk_full;
    assign pop       = (state_q == S_ACC1) && (op_q == OP_RET) && !stk_empty;

    // Stack pointer; a faulting CALL/RET leaves it untouched
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)    sp_q <= '0;
        else if (push) sp_q <= sp_q + SPW'(1);
        else if (pop)  sp_q <= stk_top;
    end

    // Stack entries need no reset: they are only read below sp
    always_ff @(posedge clk) begin
        if (push) stack_q[sp_q] <= ret_addr;
    end
`endif

    // Result, pointer and fault registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dout_q <= '0;
            ptr_q  <= '0;
`ifdef SAP_MEM_STACK_EN
            err    <= 1'b0;
`endif
        end else if (state_q == S_ACC1) begin
`ifdef SAP_MEM_STACK_EN
            err <= 1'b0;
`endif
            case (op_q)
                OP_READ: dout_q <= rdata_a;
                OP_LDI,
                OP_STA:  ptr_q  <= AW'(rdata_a);
`ifdef SAP_MEM_STACK_EN
                OP_CALL: begin
                    if (stk_full) err    <= 1'b1;
                    else          dout_q <= rdata_a;
                end
                OP_RET: begin
                    if (stk_empty) err    <= 1'b1;
                    else           dout_q <= DW'(stack_q[stk_top]);
                end
`else
                OP_CALL: dout_q <= rdata_a;
                OP_RET:  dout_q <= mem[{AW{1'b1}}];
`endif
                default: ;
            endcase
        end else if (state_q == S_ACC2) begin
            if (op_q == OP_LDI)      dout_q <= rdata_p;
            else if (op_q == OP_STA) dout_q <= DW'(ptr_q);
        end
    end

`ifndef SAP_MEM_STACK_EN
    assign err = 1'b0;
`endif

    // Single write port; all writes land on the access edge, after the read
    always_comb begin
        we    = 1'b0;
        waddr = addr_q;
        wdata = din_q;
        if (state_q == S_ACC1) begin
            case (op_q)
                OP_STD: begin
                    we    = 1'b1;
                    waddr = AW'(dout_q);
                end
                OP_WRITE: we = 1'b1;
`ifndef SAP_MEM_STACK_EN
                OP_CALL: begin
                    we    = 1'b1;
                    waddr = {AW{1'b1}};
                    wdata = DW'(ret_addr);
                end
`endif
                default: ;
            endcase
        end else if ((state_q == S_ACC2) && (op_q == OP_STA)) begin
            we    = 1'b1;
            waddr = ptr_q;
        end
    end

    // Memory array has no reset; gating on clr_n blocks a write racing reset
    always_ff @(posedge clk) begin
        if (we && clr_n) mem[waddr] <= wdata;
    end

    assign dout     = dout_q;
    assign busy     = (state_q == S_ACC1) || (state_q == S_ACC2);
    assign done     = (state_q == S_DONE);
    assign dout_bus = lf ? dout_q : {DW{1'bz}};

endmodule

// File: tb/tb_sap_mem_ctrl.sv
module tb_sap_mem_ctrl;

    localparam int SDEPTH = 4;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_LDI   = 3'b001;
    localparam logic [2:0] OP_CALL  = 3'b010;
    localparam logic [2:0] OP_STD   = 3'b011;
    localparam logic [2:0] OP_RET   = 3'b100;
    localparam logic [2:0] OP_STA   = 3'b101;
    localparam logic [2:0] OP_WRITE = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;
    logic       lf = 1'b0;
    logic [7:0] dout;
    wire  [7:0] dout_bus;
    logic       busy;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;

    sap_mem_ctrl #(.DW(8), .AW(8), .SDEPTH(SDEPTH)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .op       (op),
        .addr     (addr),
        .din      (din),
        .lf       (lf),
        .dout     (dout),
        .dout_bus (dout_bus),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, result word and return-address stack
    logic [7:0] m_mem [256];
    logic [7:0] m_dout = 8'h00;
    logic [7:0] m_stk [$];

    task automatic model_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] ed, output logic ee, output int el);
        logic [7:0] p;
        logic [7:0] ra;
        ee = 1'b0;
        el = 2;
        ra = a + 8'd1;
        case (o)
            OP_READ:  m_dout = m_mem[a];
            OP_LDI:   begin m_dout = m_mem[m_mem[a]]; el = 3; end
            OP_CALL: begin
`ifdef SAP_MEM_STACK_EN
                if (m_stk.size() == SDEPTH) ee = 1'b1;
                else begin m_dout = m_mem[a]; m_stk.push_back(ra); end
`else
                m_dout = m_mem[a];
                m_mem[255] = ra;
`endif
            end
            OP_STD:   m_mem[m_dout] = d;
            OP_RET: begin
`ifdef SAP_MEM_STACK_EN
                if (m_stk.size() == 0) ee = 1'b1;
                else m_dout = m_stk.pop_back();
`else
                m_dout = m_mem[255];
`endif
            end
            OP_STA: begin
                p = m_mem[a];
                m_mem[p] = d;
                m_dout = p;
                el = 3;
            end
            OP_WRITE: m_mem[a] = d;
            default: ;
        endcase
        ed = m_dout;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one op on the DUT; entered and left on a falling edge
    task automatic exec_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic re, output int lat);
        start = 1'b1; op = o; addr = a; din = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = dout;
        re = err;
    endtask

    task automatic run_model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] d,
                             input string nm);
        logic [7:0] ed, rd;
        logic ee, re;
        int el, lat;
        model_op(o, a, d, ed, ee, el);
        exec_op(o, a, d, rd, re, lat);
        chk({nm, " latency"}, lat, el);
        chk({nm, " dout"}, rd, ed);
        chk({nm, " err"}, re, ee);
    endtask

    task automatic run_const(input logic [2:0] o, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] xd, input logic xe, input string nm);
        logic [7:0] ed, rd;
        logic ee, re;
        int el, lat;
        model_op(o, a, d, ed, ee, el);
        exec_op(o, a, d, rd, re, lat);
        chk({nm, " dout"}, rd, xd);
        chk({nm, " err"}, re, xe);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] dout;
        logic       err;
        int         lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [7:0] ed, ed2, rd, x;
        logic ee, re;
        int el, lat;

        tbl[0]  = '{OP_WRITE, 8'h10, 8'h5A, 8'h00, 1'b0, 2};
        tbl[1]  = '{OP_READ,  8'h10, 8'h00, 8'h5A, 1'b0, 2};
        tbl[2]  = '{OP_WRITE, 8'h05, 8'h66, 8'h5A, 1'b0, 2};
        tbl[3]  = '{OP_STA,   8'h05, 8'h98, 8'h66, 1'b0, 3};
        tbl[4]  = '{OP_READ,  8'h66, 8'h00, 8'h98, 1'b0, 2};
        tbl[5]  = '{OP_LDI,   8'h05, 8'h00, 8'h98, 1'b0, 3};
        tbl[6]  = '{OP_WRITE, 8'h0C, 8'h0F, 8'h98, 1'b0, 2};
        tbl[7]  = '{OP_CALL,  8'h0C, 8'h00, 8'h0F, 1'b0, 2};
        tbl[8]  = '{OP_RET,   8'h00, 8'h00, 8'h0D, 1'b0, 2};
        tbl[9]  = '{OP_NOP,   8'h00, 8'h00, 8'h0D, 1'b0, 2};
        tbl[10] = '{OP_STD,   8'h00, 8'h77, 8'h0D, 1'b0, 2};
        tbl[11] = '{OP_READ,  8'h0D, 8'h00, 8'h77, 1'b0, 2};

        // Reset values
        lf = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset dout", dout, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset err", err, 1'b0);
        chk("reset dout_bus", dout_bus, 8'h00);
        clr_n = 1'b1;
        @(negedge clk);

        // Give every memory word a known value
        for (int i = 0; i < 256; i++) begin
            x = 8'($urandom);
            model_op(OP_WRITE, 8'(i), x, ed, ee, el);
            exec_op(OP_WRITE, 8'(i), x, rd, re, lat);
        end

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            model_op(tbl[i].op, tbl[i].addr, tbl[i].din, ed, ee, el);
            exec_op(tbl[i].op, tbl[i].addr, tbl[i].din, rd, re, lat);
            chk($sformatf("vec%0d dout", i), rd, tbl[i].dout);
            chk($sformatf("vec%0d err", i), re, tbl[i].err);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
        end

        // clr_n during STA: pointer fetched, write aborted
        run_model(OP_WRITE, 8'h30, 8'h40, "abort setup a");
        run_model(OP_WRITE, 8'h40, 8'h11, "abort setup b");
        run_model(OP_READ, 8'h30, 8'h00, "abort setup c");
        start = 1'b1; op = OP_STA; addr = 8'h30; din = 8'hEE;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        clr_n = 1'b0;
        #1;
        chk("abort dout", dout, 8'h00);
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        @(posedge clk); @(negedge clk);
        clr_n = 1'b1;
        m_dout = 8'h00;
        m_stk.delete();
        @(negedge clk);
        run_const(OP_READ, 8'h40, 8'h00, 8'h11, 1'b0, "abort target");

`ifdef SAP_MEM_STACK_EN
        for (int i = 0; i < 4; i++)
            run_model(OP_CALL, 8'h50 + 8'(i), 8'h00, $sformatf("push%0d", i));
        ed = m_dout;
        run_const(OP_CALL, 8'h60, 8'h00, ed, 1'b1, "push overflow");
        for (int i = 0; i < 4; i++)
            run_const(OP_RET, 8'h00, 8'h00, 8'h54 - 8'(i), 1'b0, $sformatf("pop%0d", i));
        run_const(OP_RET, 8'h00, 8'h00, 8'h51, 1'b1, "pop underflow");
`else
        run_model(OP_CALL, 8'h20, 8'h00, "legacy call");
        run_const(OP_READ, 8'hFF, 8'h00, 8'h21, 1'b0, "legacy slot");
        run_const(OP_RET, 8'h00, 8'h00, 8'h21, 1'b0, "legacy ret");
`endif
        run_model(OP_CALL, 8'hFF, 8'h00, "call wrap");
        run_const(OP_RET, 8'h00, 8'h00, 8'h00, 1'b0, "ret wrap");

        // Bus drive
        run_model(OP_WRITE, 8'h70, 8'hC3, "bus setup a");
        run_const(OP_READ, 8'h70, 8'h00, 8'hC3, 1'b0, "bus setup b");
        lf = 1'b1;
        #1 chk("bus lf=1", dout_bus, 8'hC3);
        lf = 1'b0;
        #1;
        tests++;
        if (dout_bus === 8'hC3) begin
            fails++;
            $display("FAIL bus lf=0: got %0h, must not drive %0h", dout_bus, 8'hC3);
        end
        lf = 1'b1;
        @(negedge clk);

        // start pulses while busy are ignored
        x = 8'h71;
        model_op(OP_LDI, 8'h05, 8'h00, ed, ee, el);
        start = 1'b1; op = OP_LDI; addr = 8'h05; din = 8'h00;
        @(posedge clk); @(negedge clk);
        op = OP_WRITE; addr = x; din = ~m_mem[x];
        chk("ignore busy acc1", busy, 1'b1);
        @(posedge clk); @(negedge clk);
        chk("ignore busy acc2", busy, 1'b1);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ignore done", done, 1'b1);
        chk("ignore dout", dout, ed);
        @(posedge clk); @(negedge clk);
        chk("ignore idle busy", busy, 1'b0);
        chk("ignore idle done", done, 1'b0);
        run_model(OP_READ, x, 8'h00, "ignore target");

        // start held through DONE: READ then NOP, no idle cycle
        model_op(OP_READ, 8'h10, 8'h00, ed, ee, el);
        model_op(OP_NOP, 8'h00, 8'h00, ed2, ee, el);
        start = 1'b1; op = OP_READ; addr = 8'h10;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("b2b done1", done, 1'b1);
        chk("b2b dout1", dout, ed);
        op = OP_NOP;
        @(posedge clk); @(negedge clk);
        chk("b2b busy2", busy, 1'b1);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("b2b done2", done, 1'b1);
        chk("b2b dout2", dout, ed2);

        // Randomized ops against the model
        for (int i = 0; i < 400; i++)
            run_model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                      $sformatf("rand%0d", i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
